myswitch_axil_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares the single AXI4-Lite slave port of the myswitch register block (4 × 32-bit registers, byte offsets 0x0–0xC) between NUM_REQ on-chip requesters.
- Each requester issues simple single-word read/write commands. The block serialises them into AXI4-Lite transactions and returns data/response to the granted requester.
- Sits between the control-plane logic and myswitch S00_AXI inside the block design.

---
 rtl/myswitch_arb_pkg.sv | 27 ++
 rtl/rr_arbiter.sv | 44 ++++
 rtl/myswitch_axil_arbiter.sv | 216 +++++++++++++++++++++
 tb/tb_myswitch_axil_arbiter.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/myswitch_arb_pkg.sv
// Shared types and constants for the myswitch AXI4-Lite request arbiter:
// FSM state encoding, AXI response codes, register offsets and an index-width helper.
package myswitch_arb_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4,
    DONE    = 3'd5
  } arb_state_e;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  localparam logic [3:0] REG0 = 4'h0;
  localparam logic [3:0] REG1 = 4'h4;
  localparam logic [3:0] REG2 = 4'h8;
  localparam logic [3:0] REG3 = 4'hC;

  // Width of a requester index; a single requester still needs one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin requester selection: combinational search starting at the
// pointer (wrapping), plus the pointer register that moves past each winner.
module rr_arbiter
  import myswitch_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  localparam int IDX_W = idx_width(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic               gnt_valid,
  output logic [IDX_W-1:0]   gnt_idx
);

  logic [IDX_W-1:0] ptr;

  // Find the first asserted request at or after the pointer; scanning from the
  // far end lets the closest candidate overwrite the others.
  always_comb begin
    int idx;
    idx       = 0;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = IDX_W'(idx);
      end
    end
  end

  // Pointer moves to the index after the winner whenever a grant is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/myswitch_axil_arbiter.sv
// Shares the myswitch S00_AXI AXI4-Lite slave between NUM_REQ requesters.
// One transaction in flight at a time, round-robin grant, response returned
// to the granted requester as a one-cycle rsp_valid pulse.
// Optional watchdog: define MYSWITCH_ARB_TIMEOUT_EN to abort stalled
// transactions with SLVERR and expose a sticky timeout_flag.
//
// Handshake rule on every channel: a transfer happens on a rising ACLK edge
// where valid and ready are both high; valid never depends on ready, and once
// raised it holds until its transfer.
module myswitch_axil_arbiter
  import myswitch_arb_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int ADDR_WIDTH     = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic [1:0]                    rsp_resp,
  output logic [ADDR_WIDTH-1:0]         M_AXI_AWADDR,
  output logic [2:0]                    M_AXI_AWPROT,
  output logic                          M_AXI_AWVALID,
  input  logic                          M_AXI_AWREADY,
  output logic [DATA_WIDTH-1:0]         M_AXI_WDATA,
  output logic [3:0]                    M_AXI_WSTRB,
  output logic                          M_AXI_WVALID,
  input  logic                          M_AXI_WREADY,
  input  logic [1:0]                    M_AXI_BRESP,
  input  logic                          M_AXI_BVALID,
  output logic                          M_AXI_BREADY,
  output logic [ADDR_WIDTH-1:0]         M_AXI_ARADDR,
  output logic [2:0]                    M_AXI_ARPROT,
  output logic                          M_AXI_ARVALID,
  input  logic                          M_AXI_ARREADY,
  input  logic [DATA_WIDTH-1:0]         M_AXI_RDATA,
  input  logic [1:0]                    M_AXI_RRESP,
  input  logic                          M_AXI_RVALID,
  output logic                          M_AXI_RREADY
`ifdef MYSWITCH_ARB_TIMEOUT_EN
  ,
  output logic                          timeout_flag
`endif
);

  localparam int IDX_W = idx_width(NUM_REQ);

  arb_state_e            state, nxt;
  logic                  gnt_valid, advance;
  logic [IDX_W-1:0]      gnt_idx, g_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  aw_done, w_done;
  logic                  busy, tmo_hit;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .clk       (ACLK),
    .rst_n     (ARESETN),
    .req       (req_valid),
    .advance   (advance),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  assign busy         = (state == WR_REQ) || (state == WR_RESP) ||
                        (state == RD_REQ) || (state == RD_RESP);
  assign M_AXI_AWADDR = addr_q;
  assign M_AXI_ARADDR = addr_q;
  assign M_AXI_WDATA  = wdata_q;
  assign M_AXI_AWPROT = 3'b000;
  assign M_AXI_ARPROT = 3'b000;
  assign M_AXI_WSTRB  = 4'hF;

`ifdef MYSWITCH_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_cnt;

  assign tmo_hit = busy && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Count cycles spent in one waiting state; any state change restarts it.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      tmo_cnt <= '0;
    end else if (!busy || (nxt != state)) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + CNT_W'(1);
    end
  end

  // Sticky record that some transaction was abandoned by the watchdog.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      timeout_flag <= 1'b0;
    end else if (tmo_hit) begin
      timeout_flag <= 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  // Next state plus every handshake output, all decoded from the current state.
  always_comb begin
    nxt           = state;
    req_ready     = '0;
    rsp_valid     = '0;
    advance       = 1'b0;
    M_AXI_AWVALID = 1'b0;
    M_AXI_WVALID  = 1'b0;
    M_AXI_BREADY  = 1'b0;
    M_AXI_ARVALID = 1'b0;
    M_AXI_RREADY  = 1'b0;
    case (state)
      IDLE: begin
        if (gnt_valid) begin
          req_ready[gnt_idx] = 1'b1;
          advance            = 1'b1;
          nxt                = req_we[gnt_idx] ? WR_REQ : RD_REQ;
        end
      end
      WR_REQ: begin
        M_AXI_AWVALID = !aw_done;
        M_AXI_WVALID  = !w_done;
        if ((aw_done || M_AXI_AWREADY) && (w_done || M_AXI_WREADY)) nxt = WR_RESP;
      end
      WR_RESP: begin
        M_AXI_BREADY = 1'b1;
        if (M_AXI_BVALID) nxt = DONE;
      end
      RD_REQ: begin
        M_AXI_ARVALID = 1'b1;
        if (M_AXI_ARREADY) nxt = RD_RESP;
      end
      RD_RESP: begin
        M_AXI_RREADY = 1'b1;
        if (M_AXI_RVALID) nxt = DONE;
      end
      DONE: begin
        rsp_valid[g_q] = 1'b1;
        nxt            = IDLE;
      end
      default: nxt = IDLE;
    endcase
    // Watchdog abort: withdraw from the bus and finish with an error.
    if (tmo_hit) begin
      M_AXI_AWVALID = 1'b0;
      M_AXI_WVALID  = 1'b0;
      M_AXI_BREADY  = 1'b0;
      M_AXI_ARVALID = 1'b0;
      M_AXI_RREADY  = 1'b0;
      nxt           = DONE;
    end
  end

  // Latch the winner's command on the grant cycle; requester inputs are ignored afterwards.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      g_q     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (advance) begin
      g_q     <= gnt_idx;
      addr_q  <= req_addr[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
      wdata_q <= req_wdata[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Track AW and W completion separately so each valid drops on its own handshake.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else if (nxt != WR_REQ) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      if (M_AXI_AWVALID && M_AXI_AWREADY) aw_done <= 1'b1;
      if (M_AXI_WVALID && M_AXI_WREADY)   w_done  <= 1'b1;
    end
  end

  // Capture the completion result; it is visible in DONE and held until the next one.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rsp_rdata <= '0;
      rsp_resp  <= OKAY;
    end else if (tmo_hit) begin
      rsp_rdata <= '0;
      rsp_resp  <= SLVERR;
    end else if (M_AXI_BVALID && M_AXI_BREADY) begin
      rsp_rdata <= '0;
      rsp_resp  <= M_AXI_BRESP;
    end else if (M_AXI_RVALID && M_AXI_RREADY) begin
      rsp_rdata <= M_AXI_RDATA;
      rsp_resp  <= M_AXI_RRESP;
    end
  end

endmodule

// File: tb/tb_myswitch_axil_arbiter.sv
// Bench for myswitch_axil_arbiter: requester driver, AXI4-Lite slave model with
// programmable ready/response delays, and a scoreboard fed by a round-robin
// reference model. Define MYSWITCH_ARB_TIMEOUT_EN to also cover the watchdog.
`timescale 1ns/1ps
module tb_myswitch_axil_arbiter;
  import myswitch_arb_pkg::*;

  localparam int NR  = 3;
  localparam int AW  = 4;
  localparam int DW  = 32;
  localparam int TMO = 16;
  localparam int EW  = NR + 2 + DW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NR-1:0]    req_valid = '0, req_we = '0, req_ready, rsp_valid;
  logic [NR*AW-1:0] req_addr = '0;
  logic [NR*DW-1:0] req_wdata = '0;
  logic [DW-1:0]    rsp_rdata;
  logic [1:0]       rsp_resp;
  logic [AW-1:0]    awaddr, araddr;
  logic [2:0]       awprot, arprot;
  logic [DW-1:0]    wdata;
  logic [3:0]       wstrb;
  logic             awvalid, wvalid, bready, arvalid, rready;
  logic             awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
  logic [1:0]       bresp = 2'b00, rresp = 2'b00;
  logic [DW-1:0]    rdata = '0;
`ifdef MYSWITCH_ARB_TIMEOUT_EN
  logic             timeout_flag;
`endif

  myswitch_axil_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)) dut (
    .ACLK(clk), .ARESETN(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
`ifdef MYSWITCH_ARB_TIMEOUT_EN
    , .timeout_flag(timeout_flag)
`endif
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int failures = 0;
  logic [EW-1:0] exp_q[$];    // {onehot requester, resp, rdata}
  logic [NR-1:0] gnt_q[$];    // expected grant order
  logic [36:0]   axi_q[$];    // {we, addr, wdata} in bus order
  int            lat_q[$];
  logic [31:0]   ref_mem[4];
  logic [31:0]   slv_mem[4];
  int            model_ptr = 0;
  int            cyc = 0;
  bit            lat_chk = 0;
  int            exp_lat = 3;
  int            aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  bit            rand_dly = 0, err_en = 0, b_never = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: one transaction's bus request and the response it must produce.
  task automatic push_expect(input int g, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic [NR-1:0] oh;
    logic [1:0]    resp;
    logic [DW-1:0] rd;
    oh = NR'(1) << g;
    gnt_q.push_back(oh);
    axi_q.push_back({we, a, d});
    if (we && b_never) begin
      resp = SLVERR; rd = '0;
    end else if (we) begin
      ref_mem[a[3:2]] = d; resp = OKAY; rd = '0;
    end else begin
      resp = (err_en && a == REG2) ? SLVERR : OKAY; rd = ref_mem[a[3:2]];
    end
    exp_q.push_back({oh, resp, rd});
  endtask

  // ---------------- driver tasks ----------------
  task automatic issue_batch(input logic [NR-1:0] mask, input logic [NR-1:0] we,
                             input logic [NR*AW-1:0] addr, input logic [NR*DW-1:0] data);
    logic [NR-1:0] pend, seen;
    int g, n;
    pend = mask;
    while (pend != 0) begin
      g = -1;
      for (int i = 0; i < NR; i++) begin
        if (g < 0 && pend[(model_ptr + i) % NR]) g = (model_ptr + i) % NR;
      end
      pend[g] = 1'b0;
      model_ptr = (g + 1) % NR;
      push_expect(g, we[g], addr[g*AW +: AW], data[g*DW +: DW]);
    end
    @(posedge clk); #1;
    req_we = we; req_addr = addr; req_wdata = data; req_valid = mask;
    pend = mask; n = 0;
    while (pend != 0 && n < 2000) begin
      @(negedge clk); seen = req_ready & req_valid;
      @(posedge clk); #1;
      req_valid = req_valid & ~seen; pend = pend & ~seen; n++;
    end
    check("grant_wait", pend, 0);
    req_valid = '0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk); n++;
    end
    check("drain_wait", exp_q.size(), 0);
    exp_q.delete(); gnt_q.delete(); lat_q.delete();
  endtask

  task automatic run_batch(input logic [NR-1:0] mask, input logic [NR-1:0] we,
                           input logic [NR*AW-1:0] addr, input logic [NR*DW-1:0] data);
    issue_batch(mask, we, addr, data);
    wait_drain();
  endtask

  task automatic one_txn(input int g, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic [NR*AW-1:0] aa;
    logic [NR*DW-1:0] dd;
    aa = '0; dd = '0;
    aa[g*AW +: AW] = a; dd[g*DW +: DW] = d;
    run_batch(NR'(1) << g, we ? (NR'(1) << g) : '0, aa, dd);
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, {req_ready, rsp_valid, rsp_rdata, rsp_resp, awvalid, wvalid, bready, arvalid, rready}, 0);
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("aw_ar_overlap", awvalid & arvalid, 0);
        if (req_ready != 0) begin
          if (gnt_q.size() == 0) check("unexpected_grant", req_ready, 0);
          else begin
            check("grant", req_ready, gnt_q.pop_front());
            lat_q.push_back(cyc);
          end
        end
        if (rsp_valid != 0) begin
          if (exp_q.size() == 0) check("unexpected_rsp", rsp_valid, 0);
          else begin
            check("rsp", {rsp_valid, rsp_resp, rsp_rdata}, exp_q.pop_front());
            if (lat_q.size() != 0) begin
              int t;
              t = lat_q.pop_front();
              if (lat_chk) check("latency", cyc - t, exp_lat);
            end
          end
        end
      end
    end
  end

  // ---------------- AXI4-Lite slave model ----------------
  initial begin : slave
    bit cur_v = 0, aw_seen = 0, w_seen = 0, ar_seen = 0, aw_hs = 0, w_hs = 0, b_pend = 0, r_pend = 0;
    int aw_w = 0, w_w = 0, b_w = 0, ar_w = 0, r_w = 0, aw_cnt = 0, w_cnt = 0;
    logic [36:0] cur = '0;
    logic [1:0]  wa = '0;
    logic [31:0] wd = '0, rd_v = '0;
    logic [1:0]  rr_v = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
        cur_v = 0; aw_seen = 0; w_seen = 0; ar_seen = 0; aw_hs = 0; w_hs = 0;
        b_pend = 0; r_pend = 0; aw_cnt = 0; w_cnt = 0;
        continue;
      end
      // response channels first, so a response never precedes its request handshake
      if (b_pend) begin
        if (b_w > 0) begin b_w--; bvalid = 0; end
        else begin
          bvalid = 1; bresp = OKAY;
          if (bready) begin
            b_pend = 0; cur_v = 0; slv_mem[wa] = wd;
            check("aw_handshakes", aw_cnt, 1);
            check("w_handshakes", w_cnt, 1);
            aw_cnt = 0; w_cnt = 0;
          end
        end
      end else bvalid = 0;
      if (r_pend) begin
        if (r_w > 0) begin r_w--; rvalid = 0; end
        else begin
          rvalid = 1; rdata = rd_v; rresp = rr_v;
          if (rready) begin r_pend = 0; cur_v = 0; end
        end
      end else begin rvalid = 0; rdata = '0; rresp = 2'b00; end
      // new transaction appearing on the bus
      if (!cur_v && (awvalid || wvalid || arvalid)) begin
        cur_v = 1;
        if (axi_q.size() == 0) check("unexpected_axi", {awvalid, wvalid, arvalid}, 0);
        else cur = axi_q.pop_front();
        if (rand_dly) begin
          aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); b_dly = $urandom_range(0, 3);
          ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3);
        end
      end
      if (awvalid) begin
        if (!aw_seen) begin aw_seen = 1; aw_w = aw_dly; end
        if (aw_w > 0) begin aw_w--; awready = 0; end
        else begin
          awready = 1; aw_seen = 0; aw_cnt++; aw_hs = 1; wa = awaddr[3:2];
          check("awaddr", {1'b1, awaddr}, cur[36:32]);
          check("awprot", awprot, 0);
        end
      end else awready = 0;
      if (wvalid) begin
        if (!w_seen) begin w_seen = 1; w_w = w_dly; end
        if (w_w > 0) begin w_w--; wready = 0; end
        else begin
          wready = 1; w_seen = 0; w_cnt++; w_hs = 1; wd = wdata;
          check("wdata", wdata, cur[31:0]);
          check("wstrb", wstrb, 4'hF);
        end
      end else wready = 0;
      if (aw_hs && w_hs) begin
        aw_hs = 0; w_hs = 0;
        if (b_never) begin cur_v = 0; aw_cnt = 0; w_cnt = 0; end
        else begin b_pend = 1; b_w = b_dly; end
      end
      if (arvalid) begin
        if (!ar_seen) begin ar_seen = 1; ar_w = ar_dly; end
        if (ar_w > 0) begin ar_w--; arready = 0; end
        else begin
          arready = 1; ar_seen = 0;
          check("araddr", {1'b0, araddr}, cur[36:32]);
          check("arprot", arprot, 0);
          r_pend = 1; r_w = r_dly; rd_v = slv_mem[araddr[3:2]];
          rr_v = (err_en && araddr == REG2) ? SLVERR : OKAY;
        end
      end else arready = 0;
    end
  end

  // ---------------- test sequence ----------------
  initial begin : main
    logic [NR-1:0]    m, w;
    logic [NR*AW-1:0] a;
    logic [NR*DW-1:0] d;
    int n;
    for (int i = 0; i < 4; i++) begin ref_mem[i] = '0; slv_mem[i] = '0; end

    // reset values
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset_outputs");
    check("const_awprot_arprot", {awprot, arprot}, 0);
    check("const_wstrb", wstrb, 4'hF);
    @(negedge clk); rst_n = 1'b1;

    // single write then read, zero-wait slave, latency checked
    lat_chk = 1; exp_lat = 3;
    one_txn(0, 1'b1, REG0, 32'h0000_0001);
    one_txn(0, 1'b0, REG0, '0);
    lat_chk = 0;

    // contention: req0 and req1 both pending, then read back every register
    a = '0; d = '0;
    a[0*AW +: AW] = REG0; d[0*DW +: DW] = 32'd1;
    a[1*AW +: AW] = REG1; d[1*DW +: DW] = 32'd2;
    run_batch(3'b011, 3'b011, a, d);
    a[0*AW +: AW] = REG2; d[0*DW +: DW] = 32'd3;
    a[1*AW +: AW] = REG3; d[1*DW +: DW] = 32'd4;
    run_batch(3'b011, 3'b011, a, d);
    one_txn(2, 1'b0, REG0, '0);
    one_txn(1, 1'b0, REG1, '0);
    one_txn(0, 1'b0, REG2, '0);
    one_txn(2, 1'b0, REG3, '0);

    // AW/W skew in both directions
    aw_dly = 0; w_dly = 3;
    one_txn(2, 1'b1, REG2, 32'hA5A5_0F0F);
    aw_dly = 3; w_dly = 0;
    one_txn(1, 1'b1, REG3, 32'h1234_5678);
    aw_dly = 0; w_dly = 0;

    // error response passed through on a read of 0x8
    err_en = 1;
    one_txn(1, 1'b0, REG2, '0);
    err_en = 0;

    // reset during RD_RESP: requester 0 reads, so the pointer would otherwise sit at 1
    r_dly = 20;
    a = '0; a[0*AW +: AW] = REG1;
    issue_batch(3'b001, 3'b000, a, '0);
    n = 0;
    while (!rready && n < 100) begin @(negedge clk); n++; end
    check("reached_rd_resp", rready, 1'b1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("reset_mid_read");
    exp_q.delete(); gnt_q.delete(); axi_q.delete(); lat_q.delete();
    model_ptr = 0; r_dly = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    a = '0; a[0*AW +: AW] = REG3; a[1*AW +: AW] = REG0;
    run_batch(3'b011, 3'b000, a, '0);

    // randomized traffic with random slave timing and error injection
    rand_dly = 1;
    for (int t = 0; t < 40; t++) begin
      m = NR'($urandom_range(1, (1 << NR) - 1));
      w = NR'($urandom);
      for (int i = 0; i < NR; i++) begin
        a[i*AW +: AW] = {2'($urandom_range(0, 3)), 2'b00};
        d[i*DW +: DW] = $urandom;
      end
      err_en = ($urandom_range(0, 3) == 0);
      run_batch(m, w, a, d);
    end
    rand_dly = 0; err_en = 0;
    aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0;

`ifdef MYSWITCH_ARB_TIMEOUT_EN
    check("timeout_flag_clear", timeout_flag, 1'b0);
    b_never = 1; lat_chk = 1; exp_lat = 2 + TMO;
    one_txn(1, 1'b1, REG3, 32'hDEAD_BEEF);
    b_never = 0; lat_chk = 0;
    check("timeout_flag_set", timeout_flag, 1'b1);
    one_txn(0, 1'b0, REG3, '0);
    check("timeout_flag_sticky", timeout_flag, 1'b1);
`endif

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
